// File: rtl/rs_multi_cdb.sv
// Reservation station: DEPTH entries, two tracked sources, NCDB-channel wakeup, registered issue port.
// Define RS_OLDEST_FIRST_EN for oldest-ready-first selection; otherwise the lowest-index ready entry issues.
module rs_multi_cdb #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int PAY_W  = 108,
  parameter int NCDB   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [PAY_W-1:0]       disp_pay,
  input  logic                   disp_q1,
  input  logic [TAG_W-1:0]       disp_t1,
  input  logic [DATA_W-1:0]      disp_v1,
  input  logic                   disp_q2,
  input  logic [TAG_W-1:0]       disp_t2,
  input  logic [DATA_W-1:0]      disp_v2,
  input  logic [TAG_W-1:0]       disp_dest,
  input  logic [NCDB-1:0]        cdb_valid,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [PAY_W-1:0]       iss_pay,
  output logic [DATA_W-1:0]      iss_v1,
  output logic [DATA_W-1:0]      iss_v2,
  output logic [TAG_W-1:0]       iss_dest,
  output logic [$clog2(DEPTH):0] count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]  busy, q1, q2, ready_vec;
  logic [TAG_W-1:0]  t1 [DEPTH];
  logic [TAG_W-1:0]  t2 [DEPTH];
  logic [DATA_W-1:0] v1 [DEPTH];
  logic [DATA_W-1:0] v2 [DEPTH];
  logic [PAY_W-1:0]  pay [DEPTH];
  logic [TAG_W-1:0]  dest [DEPTH];

  logic [IW-1:0]     free_idx, sel_idx;
  logic              sel_valid, load_en, do_disp, do_iss;
  logic              byp_q1, byp_q2;
  logic [DATA_W-1:0] byp_v1, byp_v2;

`ifdef RS_OLDEST_FIRST_EN
  // older[i][j] set means entry i was dispatched before entry j.
  logic [DEPTH-1:0]  older [DEPTH];
`endif

  assign ready_vec  = busy & ~q1 & ~q2;
  assign disp_ready = (count < CW'(DEPTH));
  assign load_en    = !iss_valid || iss_ready;
  assign do_disp    = rdy && disp_valid && disp_ready;
  assign do_iss     = rdy && load_en && sel_valid;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IW'(i);
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    for (int i = 0; i < DEPTH; i++)
      if (ready_vec[i] && &(older[i] | ~ready_vec | (DEPTH'(1) << i))) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
`else
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready_vec[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
`endif
  end

  // Same-cycle broadcast bypass for the op being dispatched; lowest channel wins.
  always_comb begin
    byp_q1 = disp_q1;
    byp_v1 = disp_v1;
    byp_q2 = disp_q2;
    byp_v2 = disp_v2;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (disp_q1 && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_t1) begin
        byp_q1 = 1'b0;
        byp_v1 = cdb_data[k*DATA_W +: DATA_W];
      end
      if (disp_q2 && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_t2) begin
        byp_q2 = 1'b0;
        byp_v2 = cdb_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy      <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
      iss_pay   <= '0;
      iss_v1    <= '0;
      iss_v2    <= '0;
      iss_dest  <= '0;
    end else if (rdy) begin
      // Descending channel order so the lowest matching channel's write lands last.
      for (int i = 0; i < DEPTH; i++)
        if (busy[i])
          for (int k = NCDB - 1; k >= 0; k--) begin
            if (q1[i] && cdb_valid[k] && t1[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
              q1[i] <= 1'b0;
              v1[i] <= cdb_data[k*DATA_W +: DATA_W];
            end
            if (q2[i] && cdb_valid[k] && t2[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
              q2[i] <= 1'b0;
              v2[i] <= cdb_data[k*DATA_W +: DATA_W];
            end
          end
      if (load_en) begin
        if (sel_valid) begin
          iss_valid     <= 1'b1;
          iss_pay       <= pay[sel_idx];
          iss_v1        <= v1[sel_idx];
          iss_v2        <= v2[sel_idx];
          iss_dest      <= dest[sel_idx];
          busy[sel_idx] <= 1'b0;
        end else begin
          iss_valid <= 1'b0;
        end
      end
      if (do_disp) begin
        busy[free_idx] <= 1'b1;
        pay[free_idx]  <= disp_pay;
        dest[free_idx] <= disp_dest;
        t1[free_idx]   <= disp_t1;
        t2[free_idx]   <= disp_t2;
        q1[free_idx]   <= byp_q1;
        q2[free_idx]   <= byp_q2;
        v1[free_idx]   <= byp_v1;
        v2[free_idx]   <= byp_v2;
`ifdef RS_OLDEST_FIRST_EN
        for (int j = 0; j < DEPTH; j++) begin
          older[free_idx][j] <= 1'b0;
          older[j][free_idx] <= (j != int'(free_idx));
        end
`endif
      end
      count <= count + CW'(do_disp) - CW'(do_iss);
    end
  end
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: directed scenarios plus random traffic against a slot/age-list reference model.
module tb_rs_multi_cdb;
  localparam int DEPTH = 16, TAG_W = 4, DATA_W = 32, PAY_W = 108, NCDB = 2;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic disp_valid = 1'b0, disp_ready;
  logic [PAY_W-1:0] disp_pay = '0;
  logic disp_q1 = 1'b0, disp_q2 = 1'b0;
  logic [TAG_W-1:0] disp_t1 = '0, disp_t2 = '0, disp_dest = '0;
  logic [DATA_W-1:0] disp_v1 = '0, disp_v2 = '0;
  logic [NCDB-1:0] cdb_valid = '0;
  logic [NCDB*TAG_W-1:0] cdb_tag = '0;
  logic [NCDB*DATA_W-1:0] cdb_data = '0;
  logic iss_valid, iss_ready = 1'b1;
  logic [PAY_W-1:0] iss_pay;
  logic [DATA_W-1:0] iss_v1, iss_v2;
  logic [TAG_W-1:0] iss_dest;
  logic [$clog2(DEPTH):0] count;

  rs_multi_cdb #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .PAY_W(PAY_W), .NCDB(NCDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pay(disp_pay),
    .disp_q1(disp_q1), .disp_t1(disp_t1), .disp_v1(disp_v1),
    .disp_q2(disp_q2), .disp_t2(disp_t2), .disp_v2(disp_v2), .disp_dest(disp_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pay(iss_pay),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_dest(iss_dest), .count(count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit started = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: slot list with a monotonically increasing dispatch sequence number.
  bit               m_busy [DEPTH];
  bit               m_q1 [DEPTH], m_q2 [DEPTH];
  logic [TAG_W-1:0] m_t1 [DEPTH], m_t2 [DEPTH], m_dest [DEPTH];
  logic [DATA_W-1:0] m_v1 [DEPTH], m_v2 [DEPTH];
  logic [PAY_W-1:0] m_pay [DEPTH];
  longint           m_age [DEPTH];
  longint           m_seq = 0;
  bit               m_iv = 1'b0;
  logic [PAY_W-1:0] m_ipay = '0;
  logic [DATA_W-1:0] m_iv1 = '0, m_iv2 = '0;
  logic [TAG_W-1:0] m_idest = '0;

  logic [TAG_W-1:0]  log_dest [$];
  logic [DATA_W-1:0] log_v1 [$], log_v2 [$];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_step();
    int pick = -1, slot = -1, n;
    bit q;
    logic [DATA_W-1:0] v;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      m_iv = 1'b0; m_ipay = '0; m_iv1 = '0; m_iv2 = '0; m_idest = '0;
      return;
    end
    if (!rdy) return;
    n = m_count();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && !m_q1[i] && !m_q2[i]) begin
`ifdef RS_OLDEST_FIRST_EN
        if (pick < 0 || m_age[i] < m_age[pick]) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
      if (!m_busy[i] && slot < 0) slot = i;
    end
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i])
        for (int k = 0; k < NCDB; k++) if (cdb_valid[k]) begin
          if (m_q1[i] && m_t1[i] == cdb_tag[k*TAG_W +: TAG_W]) begin m_q1[i] = 1'b0; m_v1[i] = cdb_data[k*DATA_W +: DATA_W]; end
          if (m_q2[i] && m_t2[i] == cdb_tag[k*TAG_W +: TAG_W]) begin m_q2[i] = 1'b0; m_v2[i] = cdb_data[k*DATA_W +: DATA_W]; end
        end
    if (!m_iv || iss_ready) begin
      if (pick >= 0) begin
        m_iv = 1'b1; m_ipay = m_pay[pick]; m_iv1 = m_v1[pick]; m_iv2 = m_v2[pick]; m_idest = m_dest[pick];
        m_busy[pick] = 1'b0;
      end else m_iv = 1'b0;
    end
    if (disp_valid && n < DEPTH) begin
      m_busy[slot] = 1'b1; m_pay[slot] = disp_pay; m_dest[slot] = disp_dest;
      m_t1[slot] = disp_t1; m_t2[slot] = disp_t2;
      q = disp_q1; v = disp_v1;
      for (int k = 0; k < NCDB; k++)
        if (q && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_t1) begin q = 1'b0; v = cdb_data[k*DATA_W +: DATA_W]; end
      m_q1[slot] = q; m_v1[slot] = v;
      q = disp_q2; v = disp_v2;
      for (int k = 0; k < NCDB; k++)
        if (q && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_t2) begin q = 1'b0; v = cdb_data[k*DATA_W +: DATA_W]; end
      m_q2[slot] = q; m_v2[slot] = v;
      m_age[slot] = m_seq++;
    end
  endtask

  always @(posedge clk) begin
    if (started && !rst && !flush && rdy && iss_valid && iss_ready) begin
      log_dest.push_back(iss_dest); log_v1.push_back(iss_v1); log_v2.push_back(iss_v2);
    end
    model_step();
    if (rst) started = 1'b1;
    #2;
    if (started) begin
      chk("iss_valid", iss_valid, m_iv);
      chk("iss_dest", iss_dest, m_idest);
      chk("iss_v1", iss_v1, m_iv1);
      chk("iss_v2", iss_v2, m_iv2);
      chk("iss_pay", iss_pay, m_ipay);
      chk("count", count, m_count());
      chk("disp_ready", disp_ready, m_count() < DEPTH);
    end
  end

  function automatic logic [PAY_W-1:0] rand_pay();
    logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
    return r[PAY_W-1:0];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = '0; flush = 1'b0; rst = 1'b0; rdy = 1'b1; iss_ready = 1'b1;
  endtask

  task automatic disp(input logic [TAG_W-1:0] d, input bit a1, input logic [TAG_W-1:0] b1, input logic [DATA_W-1:0] c1,
                      input bit a2, input logic [TAG_W-1:0] b2, input logic [DATA_W-1:0] c2);
    disp_valid = 1'b1; disp_dest = d; disp_pay = rand_pay();
    disp_q1 = a1; disp_t1 = b1; disp_v1 = c1;
    disp_q2 = a2; disp_t2 = b2; disp_v2 = c2;
  endtask

  task automatic bcast(input int ch, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = tag;
    cdb_data[ch*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    logic [TAG_W-1:0] first_exp;
    rst = 1'b1;
    tick(2);
    idle();
    chk("rst_count", count, 0);
    chk("rst_valid", iss_valid, 0);
    chk("rst_disp_ready", disp_ready, 1);

    // Two-edge latency for an op with both sources ready.
    disp(3, 0, 0, 5, 0, 0, 7); tick; idle();
    chk("lat_e1_valid", iss_valid, 0);
    chk("lat_e1_count", count, 1);
    tick;
    chk("lat_valid", iss_valid, 1);
    chk("lat_v1", iss_v1, 5);
    chk("lat_v2", iss_v2, 7);
    chk("lat_dest", iss_dest, 3);
    chk("lat_count", count, 0);
    tick(2);

    // Fill to capacity, try one more, then wake everything from channel 1.
    for (int i = 0; i < DEPTH; i++) begin disp(TAG_W'(i), 1, 9, 0, 0, 0, i); tick; end
    chk("fill_count", count, DEPTH);
    chk("fill_disp_ready", disp_ready, 0);
    disp(15, 0, 0, 1, 0, 0, 1); tick; idle();
    chk("fill_17th_count", count, DEPTH);
    log_dest.delete(); log_v1.delete(); log_v2.delete();
    bcast(1, 9, 32'hABCD); tick; idle(); tick(20);
    chk("fill_issued", log_v1.size(), DEPTH);
    foreach (log_v1[i]) chk("fill_v1", log_v1[i], 32'hABCD);
    chk("fill_drained", count, 0);

    // Dispatch bypass from channel 0 in the same cycle.
    log_dest.delete(); log_v1.delete(); log_v2.delete();
    disp(6, 0, 0, 1, 1, 4, 0); bcast(0, 4, 32'h55); tick; idle(); tick(3);
    chk("byp_issued", log_v2.size(), 1);
    if (log_v2.size() >= 1) chk("byp_v2", log_v2[0], 32'h55);

    // Ordering: A lands in slot 5, B later in slot 2, both wait on tag 7.
    for (int i = 0; i < 6; i++) begin
      if (i == 5)      disp(5, 0, 0, 0, 0, 0, 0);
      else if (i == 2) disp(2, 1, 13, 0, 0, 0, 0);
      else             disp(TAG_W'(i), 1, 14, 0, 0, 0, 0);
      tick;
    end
    idle(); tick(3);
    disp(10, 1, 7, 0, 0, 0, 0); tick; idle();
    bcast(0, 13, 32'h13); tick; idle(); tick(3);
    disp(11, 1, 7, 0, 0, 0, 0); tick; idle(); tick;
    log_dest.delete(); log_v1.delete(); log_v2.delete();
    bcast(0, 7, 32'h77); tick; idle(); tick(4);
`ifdef RS_OLDEST_FIRST_EN
    first_exp = 10;
`else
    first_exp = 11;
`endif
    chk("ord_issued", log_dest.size(), 2);
    if (log_dest.size() >= 1) chk("ord_first", log_dest[0], first_exp);
    bcast(0, 14, 32'h14); tick; idle(); tick(8);
    chk("ord_drained", count, 0);

    // Backpressure: two ready ops, output held for three cycles.
    iss_ready = 1'b0;
    disp(1, 0, 0, 32'h11, 0, 0, 32'h12); tick;
    disp(2, 0, 0, 32'h21, 0, 0, 32'h22); tick;
    idle(); iss_ready = 1'b0; tick(3);
    chk("bp_dest", iss_dest, 1);
    chk("bp_count", count, 1);
    log_dest.delete(); log_v1.delete(); log_v2.delete();
    iss_ready = 1'b1; tick(4);
    chk("bp_issued", log_dest.size(), 2);
    if (log_dest.size() >= 1) chk("bp_first", log_dest[0], 1);

    // Flush with six resident entries, a held output and a simultaneous dispatch.
    iss_ready = 1'b0;
    disp(1, 0, 0, 1, 0, 0, 1); tick;
    for (int i = 0; i < 6; i++) begin disp(TAG_W'(8 + i), 1, 12, 0, 0, 0, 0); tick; end
    idle(); iss_ready = 1'b0; tick;
    chk("fl_pre_count", count, 6);
    chk("fl_pre_valid", iss_valid, 1);
    disp(4, 0, 0, 3, 0, 0, 3); flush = 1'b1; iss_ready = 1'b0; tick;
    chk("fl_count", count, 0);
    chk("fl_valid", iss_valid, 0);
    idle(); bcast(0, 12, 32'hC); tick; idle(); tick(3);
    chk("fl_post_count", count, 0);
    chk("fl_post_valid", iss_valid, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 6)
        disp(TAG_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)), $urandom);
      else disp_valid = 1'b0;
      for (int k = 0; k < NCDB; k++) begin
        cdb_valid[k] = ($urandom_range(0, 2) == 0);
        cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
        cdb_data[k*DATA_W +: DATA_W] = $urandom;
      end
      iss_ready = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 9);
      flush = ($urandom_range(0, 199) == 0);
      tick;
    end
    idle(); tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
